// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Summary  : Round-robin arbiter sharing one synchronous-read data memory
//            between the controller (port A) and a host loader (port B),
//            with a bounded host burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam logic [3:0] C_LOCK_MAX = 4'(LOCK_MAX);

    port_t      r_last;
    logic [3:0] r_lock_cnt;
    logic       r_a_rvalid;
    logic       r_b_rvalid;

    logic       w_a_gnt;
    logic       w_b_gnt;
    logic       w_force_a;
    logic       w_lock_hold;

    assign w_force_a   = (r_lock_cnt >= C_LOCK_MAX);
    assign w_lock_hold = (r_last == PORT_B) && b_lock && (r_lock_cnt < C_LOCK_MAX);

    // Grants are suppressed entirely while reset is held low.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (reset) begin
            if (a_req && b_req) begin
                if (w_force_a) begin
                    w_a_gnt = 1'b1;
                end else if (w_lock_hold) begin
                    w_b_gnt = 1'b1;
                end else if (r_last == PORT_B) begin
                    w_a_gnt = 1'b1;
                end else begin
                    w_b_gnt = 1'b1;
                end
            end else begin
                w_a_gnt = a_req;
                w_b_gnt = b_req;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        if (w_a_gnt) begin
            mem_addr  = a_addr;
            mem_wr    = a_we;
            mem_wdata = a_wdata;
        end else if (w_b_gnt) begin
            mem_addr  = b_addr;
            mem_wr    = b_we;
            mem_wdata = b_wdata;
        end
    end

    // The lock counter only advances while A is actually being held off;
    // an idle A leaves the count untouched so the host keeps its burst.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last     <= PORT_B;
            r_lock_cnt <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_gnt & ~a_we;
            r_b_rvalid <= w_b_gnt & ~b_we;
            if (w_a_gnt) begin
                r_last     <= PORT_A;
                r_lock_cnt <= '0;
            end else if (w_b_gnt) begin
                r_last <= PORT_B;
                if (!b_lock) begin
                    r_lock_cnt <= '0;
                end else if (a_req) begin
                    r_lock_cnt <= r_lock_cnt + 4'd1;
                end
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign rdata    = mem_rdata;

endmodule
`default_nettype wire
